load_align_unit: RTL

- Load-side counterpart of the byte-store merge path: issues a word-aligned read to data memory, waits for the returned word, then extracts the addressed byte or halfword and zero- or sign-extends it to 32 bits.
- Sits between the EX/MEM load control and the data-memory read port.
- Handles a multi-cycle memory handshake and a bounded response timeout.

---
 rtl/load_align_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/load_align_unit.sv
// load_align_unit: load-side byte/halfword alignment unit.
// Issues a word-aligned read to data memory, waits (bounded by TIMEOUT)
// for the returned word, then extracts the addressed byte/halfword and
// zero- or sign-extends it to 32 bits.
// Optional feature macro: LOAD_MISALIGN_TRAP_EN -- when defined, misaligned
// halfword/word loads are answered with an error and no memory read.
module load_align_unit #(
    parameter int TIMEOUT = 255,  // max WAIT cycles before error; 0 = never time out
    parameter int CNT_W   = 8     // timeout counter width, must hold TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic        mem_rd_valid,
    input  logic [31:0] mem_rd_data,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        load_err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
    localparam bit               TMO_EN = (TIMEOUT != 0);

    state_t           state;
    logic [1:0]       off_q;
    logic [1:0]       size_q;
    logic             sgn_q;
    logic [CNT_W-1:0] cnt;
    logic             misalign;

    // Little-endian lane select plus zero/sign extension; matches the store merge lanes.
    function automatic logic [31:0] extract(input logic [31:0] w,
                                            input logic [1:0]  off,
                                            input logic [1:0]  size,
                                            input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[7:0];
        unique case (off)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        unique case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = w;  // word and the reserved 11 encoding pass through
        endcase
        return r;
    endfunction

`ifdef LOAD_MISALIGN_TRAP_EN
    // Halfword at an odd address, or word not on a 4-byte boundary, is trapped.
    assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    // Low offset bits are silently ignored; only a timeout produces an error.
    assign misalign = 1'b0;
`endif

    // Request/response FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            load_valid <= 1'b0;
            load_data  <= '0;
            load_err   <= 1'b0;
            busy       <= 1'b0;
            cnt        <= '0;
            off_q      <= '0;
            size_q     <= '0;
            sgn_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        off_q     <= req_addr[1:0];
                        size_q    <= req_size;
                        sgn_q     <= req_signed;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (misalign) begin
                            // Skip the memory access entirely and answer with an error.
                            state      <= RESP;
                            load_valid <= 1'b1;
                            load_err   <= 1'b1;
                            load_data  <= '0;
                        end else begin
                            state     <= ISSUE;
                            mem_rd_en <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    mem_rd_en <= 1'b0;
                    cnt       <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (mem_rd_valid) begin
                        // Returned data wins over a timeout expiring in the same cycle.
                        load_data  <= extract(mem_rd_data, off_q, size_q, sgn_q);
                        load_err   <= 1'b0;
                        load_valid <= 1'b1;
                        state      <= RESP;
                    end else if (TMO_EN && (cnt == TMO)) begin
                        load_data  <= '0;
                        load_err   <= 1'b1;
                        load_valid <= 1'b1;
                        state      <= RESP;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    load_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
